dvp_camera_emu: RTL and testbench

Synthesizable OV5640-style DVP source. It generates PCLK, VSYNC, HREF and 8-bit data carrying RGB565 pixels, high byte first, at a programmable frame geometry. It drives the `OV5640` capture path on the board in place of the real sensor, for bring-up and hardware loopback. Its default geometry and blanking equal the simulation stimulus used for the capture path, so captured images can be compared between simulation and hardware.

---
 rtl/dvp_pkg.sv | 40 ++++
 rtl/dvp_pattern_src.sv | 25 ++
 rtl/dvp_camera_emu.sv | 196 +++++++++++++++++++
 tb/tb_dvp_camera_emu.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dvp_pkg.sv
// Shared types and constants for the DVP camera emulator: FSM states,
// pattern_sel encodings and the RGB565 colour-bar palette.
package dvp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VSYNC,
        ST_VBACK,
        ST_ACTIVE,
        ST_HBLANK
    } state_t;

    localparam logic [1:0] PAT_INCR  = 2'd0;
    localparam logic [1:0] PAT_BARS  = 2'd1;
    localparam logic [1:0] PAT_GRID  = 2'd2;
    localparam logic [1:0] PAT_SOLID = 2'd3;

    localparam logic [15:0] BAR_WHITE   = 16'hFFFF;
    localparam logic [15:0] BAR_YELLOW  = 16'hFFE0;
    localparam logic [15:0] BAR_CYAN    = 16'h07FF;
    localparam logic [15:0] BAR_GREEN   = 16'h07E0;
    localparam logic [15:0] BAR_MAGENTA = 16'hF81F;
    localparam logic [15:0] BAR_RED     = 16'hF800;
    localparam logic [15:0] BAR_BLUE    = 16'h001F;
    localparam logic [15:0] BAR_BLACK   = 16'h0000;

    function automatic logic [15:0] bar_colour(input logic [2:0] idx);
        case (idx)
            3'd0:    return BAR_WHITE;
            3'd1:    return BAR_YELLOW;
            3'd2:    return BAR_CYAN;
            3'd3:    return BAR_GREEN;
            3'd4:    return BAR_MAGENTA;
            3'd5:    return BAR_RED;
            3'd6:    return BAR_BLUE;
            default: return BAR_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/dvp_pattern_src.sv
// Combinational RGB565 pixel generator for the non-counting test patterns.
// INCR is byte-oriented and is produced by the top level instead.
module dvp_pattern_src
    import dvp_pkg::*;
(
    input  logic [3:0]  x,        // only the low nibble of x/y matters (grid pitch 16)
    input  logic [3:0]  y,
    input  logic [1:0]  mode,
    input  logic [15:0] solid,
    input  logic [2:0]  bar_idx,
    output logic [15:0] pixel
);

    always_comb begin
        // NOTE: default first, so every path assigns pixel and no latch is inferred.
        pixel = 16'h0000;
        case (mode)
            PAT_BARS:  pixel = bar_colour(bar_idx);
            PAT_GRID:  pixel = (x == 4'd0 || y == 4'd0) ? 16'hFFFF : 16'h0000;
            PAT_SOLID: pixel = solid;
            default:   pixel = 16'h0000;
        endcase
    end

endmodule

// File: rtl/dvp_camera_emu.sv
// OV5640-style DVP source: PCLK divider, frame FSM, line/byte/bar counters
// and registered VSYNC/HREF/data outputs that change on PCLK falling edges.
module dvp_camera_emu
    import dvp_pkg::*;
#(
    parameter int WIDTH   = 160,
    parameter int HEIGHT  = 128,
    parameter int VS_LEN  = 4,
    parameter int VS_BACK = 10,
    parameter int H_BLANK = 10,
    parameter int CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    input  logic [15:0] solid_rgb,
    output logic        cam_pclk,
    output logic        cam_vsync,
    output logic        cam_href,
    output logic [7:0]  cam_data,
    output logic        frame_done,
    output logic [15:0] frame_cnt
);

    localparam int DW     = $clog2(CLK_DIV);
    localparam int BW     = $clog2(2 * WIDTH);
    localparam int LW     = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int BAR_PX = WIDTH / 8;
    localparam int PW     = (BAR_PX > 1) ? $clog2(BAR_PX) : 1;

    logic [DW-1:0] div_cnt, div_next;
    logic          tick;

    state_t        state, state_next;
    logic [15:0]   cnt, cnt_next;
    logic [BW-1:0] byte_cnt, byte_next;
    logic [LW-1:0] line_cnt, line_next;
    logic [2:0]    bar_idx, bar_idx_next;
    logic [PW-1:0] bar_px, bar_px_next;
    logic          frame_end, frame_start;

    logic [1:0]    mode_q;
    logic [15:0]   solid_q;
    logic [7:0]    incr_cnt;
    logic [15:0]   pixel;
    logic [7:0]    data_next;

    assign tick     = (div_cnt == DW'(CLK_DIV - 1));
    assign div_next = tick ? '0 : div_cnt + DW'(1);

    always_ff @(posedge clk) begin
        // NOTE: sequential state is only ever assigned with <=, so every
        // register samples the pre-edge values of the others.
        if (rst) state <= ST_IDLE;
        else if (tick) state <= state_next;
    end

    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        byte_next    = byte_cnt;
        line_next    = line_cnt;
        bar_idx_next = bar_idx;
        bar_px_next  = bar_px;
        frame_end    = 1'b0;
        if (tick) begin
            case (state)
                ST_IDLE: begin
                    if (enable) begin
                        state_next = ST_VSYNC;
                        cnt_next   = '0;
                    end
                end
                ST_VSYNC: begin
                    if (cnt == 16'(VS_LEN - 1)) begin
                        state_next = ST_VBACK;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + 16'd1;
                    end
                end
                ST_VBACK: begin
                    if (cnt == 16'(VS_BACK - 1)) begin
                        state_next   = ST_ACTIVE;
                        byte_next    = '0;
                        line_next    = '0;
                        bar_idx_next = '0;
                        bar_px_next  = '0;
                    end else begin
                        cnt_next = cnt + 16'd1;
                    end
                end
                ST_ACTIVE: begin
                    if (byte_cnt == BW'(2 * WIDTH - 1)) begin
                        state_next = ST_HBLANK;
                        cnt_next   = '0;
                    end else begin
                        byte_next = byte_cnt + BW'(1);
                        // Leaving an odd byte means the next byte starts a new pixel.
                        if (byte_cnt[0]) begin
                            if (bar_px == PW'(BAR_PX - 1)) begin
                                bar_px_next  = '0;
                                bar_idx_next = bar_idx + 3'd1;
                            end else begin
                                bar_px_next = bar_px + PW'(1);
                            end
                        end
                    end
                end
                ST_HBLANK: begin
                    if (cnt == 16'(H_BLANK - 1)) begin
                        cnt_next = '0;
                        if (line_cnt == LW'(HEIGHT - 1)) begin
                            frame_end  = 1'b1;
                            state_next = enable ? ST_VSYNC : ST_IDLE;
                        end else begin
                            state_next   = ST_ACTIVE;
                            line_next    = line_cnt + LW'(1);
                            byte_next    = '0;
                            bar_idx_next = '0;
                            bar_px_next  = '0;
                        end
                    end else begin
                        cnt_next = cnt + 16'd1;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    assign frame_start = tick && (state_next == ST_VSYNC) && (state != ST_VSYNC);

    // Pixel for the byte about to be presented, so data lands with HREF.
    dvp_pattern_src u_pattern (
        .x       (4'(byte_next >> 1)),
        .y       (4'(line_next)),
        .mode    (mode_q),
        .solid   (solid_q),
        .bar_idx (bar_idx_next),
        .pixel   (pixel)
    );

    always_comb begin
        data_next = 8'h00;
        if (state_next == ST_ACTIVE) begin
            if (mode_q == PAT_INCR) data_next = incr_cnt + 8'd1;
            else                    data_next = byte_next[0] ? pixel[7:0] : pixel[15:8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt    <= '0;
            cam_pclk   <= 1'b0;
            cam_vsync  <= 1'b0;
            cam_href   <= 1'b0;
            cam_data   <= 8'h00;
            frame_done <= 1'b0;
            frame_cnt  <= 16'd0;
            incr_cnt   <= 8'h00;
            cnt        <= '0;
            byte_cnt   <= '0;
            line_cnt   <= '0;
            bar_idx    <= '0;
            bar_px     <= '0;
            mode_q     <= PAT_INCR;
            solid_q    <= 16'h0000;
        end else begin
            div_cnt    <= div_next;
            cam_pclk   <= (div_next >= DW'(CLK_DIV / 2));
            frame_done <= 1'b0;
            if (tick) begin
                cnt       <= cnt_next;
                byte_cnt  <= byte_next;
                line_cnt  <= line_next;
                bar_idx   <= bar_idx_next;
                bar_px    <= bar_px_next;
                cam_vsync <= (state_next == ST_VSYNC);
                cam_href  <= (state_next == ST_ACTIVE);
                cam_data  <= data_next;
                if (state_next == ST_ACTIVE) incr_cnt <= incr_cnt + 8'd1;
                if (frame_start) begin
                    mode_q  <= pattern_sel;
                    solid_q <= solid_rgb;
                end
                if (frame_end) begin
                    frame_done <= 1'b1;
                    frame_cnt  <= frame_cnt + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_dvp_camera_emu.sv
// Scoreboard bench for dvp_camera_emu: a frame-level reference model queues
// expected bytes; a monitor on PCLK rising edges checks data and timing.
module tb_dvp_camera_emu;
    import dvp_pkg::*;

    localparam int W   = 32;
    localparam int H   = 18;
    localparam int VSL = 2;
    localparam int VSB = 3;
    localparam int HB  = 4;
    localparam int DIV = 4;
    localparam int FRAME_BUDGET = 3 * DIV * (VSL + VSB + H * (2 * W + HB));

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [1:0]  pattern_sel = 2'd0;
    logic [15:0] solid_rgb = 16'h0000;
    logic        cam_pclk, cam_vsync, cam_href, frame_done;
    logic [7:0]  cam_data;
    logic [15:0] frame_cnt;

    dvp_camera_emu #(
        .WIDTH(W), .HEIGHT(H), .VS_LEN(VSL), .VS_BACK(VSB), .H_BLANK(HB), .CLK_DIV(DIV)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .pattern_sel(pattern_sel),
        .solid_rgb(solid_rgb), .cam_pclk(cam_pclk), .cam_vsync(cam_vsync),
        .cam_href(cam_href), .cam_data(cam_data), .frame_done(frame_done),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_pass = 0;
    logic [7:0] exp_q[$];
    logic [7:0] incr_m = 8'h00;
    logic       abort = 1'b0;
    int         mon_lines = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [15:0] ref_pixel(input int mode, input logic [15:0] solid,
                                              input int x, input int y);
        logic [15:0] bars [8];
        bars = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000};
        case (mode)
            1:       return bars[x / (W / 8)];
            2:       return (x % 16 == 0 || y % 16 == 0) ? 16'hFFFF : 16'h0000;
            3:       return solid;
            default: return 16'h0000;
        endcase
    endfunction

    // Queue every byte of one frame; the INCR counter runs on every active byte.
    task automatic push_frame(input int mode, input logic [15:0] solid);
        logic [15:0] pix;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                for (int b = 0; b < 2; b++) begin
                    incr_m = incr_m + 8'd1;
                    pix = ref_pixel(mode, solid, x, y);
                    if (mode == 0)   exp_q.push_back(incr_m);
                    else if (b == 0) exp_q.push_back(pix[15:8]);
                    else             exp_q.push_back(pix[7:0]);
                end
    endtask

    initial begin : monitor
        logic pv_pclk, pv_href, pv_vsync, pv_fd;
        logic [7:0] exp_b;
        int pclk_idx, vs_idx, vs_w, line_bytes;
        pv_pclk = 0; pv_href = 0; pv_vsync = 0; pv_fd = 0;
        pclk_idx = 0; vs_idx = 0; vs_w = 0; line_bytes = 0;
        forever begin
            @(negedge clk);
            if (abort) begin
                pv_pclk = 0; pv_href = 0; pv_vsync = 0; pv_fd = 0;
                vs_w = 0; line_bytes = 0; mon_lines = 0;
                continue;
            end
            if (frame_done) begin
                check("frame_done_lines", mon_lines, H);
                check("frame_done_one_clk", {31'd0, pv_fd}, 0);
            end
            pv_fd = frame_done;
            if (cam_pclk && !pv_pclk) begin
                pclk_idx++;
                if (cam_vsync) begin
                    if (!pv_vsync) begin
                        vs_idx = pclk_idx;
                        vs_w = 0;
                        mon_lines = 0;
                    end
                    vs_w++;
                end else if (pv_vsync) begin
                    check("vsync_width", vs_w, VSL);
                end
                if (cam_href) begin
                    if (!pv_href) begin
                        line_bytes = 0;
                        if (mon_lines == 0) check("vsync_to_href", pclk_idx - vs_idx, VSL + VSB);
                    end
                    if (exp_q.size() == 0) begin
                        check("sb_nonempty", {31'd0, exp_q.size() != 0}, 1);
                    end else begin
                        exp_b = exp_q.pop_front();
                        check($sformatf("data_l%0d_b%0d", mon_lines, line_bytes), cam_data, exp_b);
                    end
                    line_bytes++;
                end else begin
                    check("blank_data", cam_data, 0);
                    if (pv_href) begin
                        check("line_bytes", line_bytes, 2 * W);
                        mon_lines++;
                    end
                end
                pv_vsync = cam_vsync;
                pv_href  = cam_href;
            end
            pv_pclk = cam_pclk;
        end
    end

    task automatic wait_frame_done(input string name);
        logic got = 0;
        for (int i = 0; i < FRAME_BUDGET && !got; i++) begin
            @(negedge clk);
            if (frame_done) got = 1;
        end
        check(name, {31'd0, got}, 1);
    endtask

    task automatic wait_vsync(input string name);
        logic got = 0;
        for (int i = 0; i < FRAME_BUDGET && !got; i++) begin
            @(negedge clk);
            if (cam_vsync) got = 1;
        end
        check(name, {31'd0, got}, 1);
    endtask

    task automatic wait_lines(input string name, input int k);
        logic got = 0;
        for (int i = 0; i < FRAME_BUDGET && !got; i++) begin
            @(negedge clk);
            if (mon_lines == k && cam_href) got = 1;
        end
        check(name, {31'd0, got}, 1);
    endtask

    initial begin : stimulus
        int busy;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_pclk", {31'd0, cam_pclk}, 0);
        check("rst_vsync", {31'd0, cam_vsync}, 0);
        check("rst_href", {31'd0, cam_href}, 0);
        check("rst_data", cam_data, 0);
        check("rst_frame_done", {31'd0, frame_done}, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        rst = 1'b0;

        // Frame 1 INCR, frame 2 BARS, frame 3 SOLID, frame 4 GRID, frame 5 INCR.
        pattern_sel = 2'd0;
        push_frame(0, 16'h0000);
        enable = 1'b1;
        wait_vsync("f1_start");
        pattern_sel = 2'd1;
        push_frame(1, 16'h0000);
        wait_frame_done("f1_done");
        check("frame_cnt_f1", frame_cnt, 1);
        pattern_sel = 2'd3;
        solid_rgb   = 16'hA5C3;
        push_frame(3, 16'hA5C3);
        wait_frame_done("f2_done");
        check("frame_cnt_f2", frame_cnt, 2);
        wait_lines("f3_mid", 5);
        pattern_sel = 2'd2;
        solid_rgb   = 16'h1234;
        push_frame(2, 16'h0000);
        wait_frame_done("f3_done");
        check("frame_cnt_f3", frame_cnt, 3);
        pattern_sel = 2'd0;
        push_frame(0, 16'h0000);
        wait_frame_done("f4_done");
        check("frame_cnt_f4", frame_cnt, 4);
        wait_lines("f5_mid", 9);
        enable = 1'b0;
        wait_frame_done("f5_done");
        check("frame_cnt_f5", frame_cnt, 5);

        busy = 0;
        repeat (1000) begin
            @(negedge clk);
            if (cam_vsync || cam_href) busy++;
        end
        check("idle_quiet", busy, 0);
        check("idle_frame_cnt", frame_cnt, 5);
        check("idle_queue_empty", exp_q.size(), 0);

        // Reset in the middle of an active line, then restart from scratch.
        enable = 1'b1;
        push_frame(0, 16'h0000);
        wait_lines("f6_mid", 2);
        repeat (7) @(negedge clk);
        @(posedge clk);
        #1;
        rst   = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_pclk", {31'd0, cam_pclk}, 0);
        check("mid_rst_vsync", {31'd0, cam_vsync}, 0);
        check("mid_rst_href", {31'd0, cam_href}, 0);
        check("mid_rst_data", cam_data, 0);
        check("mid_rst_frame_cnt", frame_cnt, 0);
        check("mid_rst_state", 32'(dut.state), 32'(ST_IDLE));
        exp_q.delete();
        incr_m = 8'h00;
        push_frame(0, 16'h0000);
        check("restart_first_byte_model", exp_q[0], 8'h01);
        rst   = 1'b0;
        abort = 1'b0;
        wait_vsync("f7_start");
        enable = 1'b0;
        wait_frame_done("f7_done");
        check("frame_cnt_after_rst", frame_cnt, 1);
        repeat (20) @(negedge clk);
        check("final_queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
